// File: rtl/bamf_run_monitor.sv
// ---------------------------------------------------------------------------
// bamf_run_monitor
//
// Run controller and cycle counter wrapped around the BAMF datapath. Operands
// are queued in a small FIFO. Each one is popped onto the datapath inport.
// The processor is then restarted and released, and the monitor counts clock
// cycles until the datapath reports a write to its outport. The captured
// value, the cycle count and a timeout flag come back through a ready/valid
// result port.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   op_valid/op_ready/op_data
//                  operand input handshake (op_ready = FIFO not full)
//   cpu_inport     operand presented to the datapath inport
//   cpu_restart    one-cycle pulse that resets datapath PC and state
//   cpu_run        high while the datapath may execute
//   cpu_out_valid  datapath wrote its outport this cycle
//   cpu_outport    datapath outport value
//   res_valid/res_ready
//                  result handshake
//   res_data       captured outport value (0 on timeout)
//   res_cycles     run cycles consumed
//   res_timeout    run ended by the MAX_CYCLES bound
//   busy           not idle, or operands still queued
// ---------------------------------------------------------------------------
module bamf_run_monitor #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 32,
    parameter int DEPTH      = 4,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [DATA_W-1:0] op_data,
    output logic [DATA_W-1:0] cpu_inport,
    output logic              cpu_restart,
    output logic              cpu_run,
    input  logic              cpu_out_valid,
    input  logic [DATA_W-1:0] cpu_outport,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              res_timeout,
    output logic              busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic [1:0]        state;
    logic [CNT_W-1:0]  run_count;
    logic [CNT_W-1:0]  count_next;
    logic              push;
    logic              pop;

    // op_ready comes from the registered count only, so a pop in IDLE does
    // not open a slot for a push in the same cycle.
    assign op_ready   = (fifo_count != DEPTH_CNT);
    assign push       = op_valid && op_ready;
    assign pop        = (state == IDLE) && (fifo_count != '0);
    assign count_next = run_count + CNT_W'(1);

    // Control outputs are decodes of the state register and FIFO count, so
    // none of them has a combinational path from an input.
    assign cpu_restart = (state == START);
    assign cpu_run     = (state == RUN);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE) || (fifo_count != '0);

    // Operand storage: no reset needed, the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= op_data;
        end
    end

    // FIFO pointers and occupancy. DEPTH is a power of two, so the
    // pointers wrap on their own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Run sequencer. IDLE pops an operand, START restarts the datapath and
    // clears the counter, and RUN counts until an outport write or the cycle
    // bound. DONE holds the result until the consumer takes it. A valid
    // outport write in the bounding cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            run_count   <= '0;
            cpu_inport  <= '0;
            res_data    <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cpu_inport <= fifo_mem[rd_ptr];
                        state      <= START;
                    end
                end
                START: begin
                    run_count <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    run_count <= count_next;
                    if (cpu_out_valid) begin
                        res_data    <= cpu_outport;
                        res_cycles  <= count_next;
                        res_timeout <= 1'b0;
                        state       <= DONE;
                    end else if (count_next == MAX_CNT) begin
                        res_data    <= '0;
                        res_cycles  <= MAX_CNT;
                        res_timeout <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bamf_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_bamf_run_monitor
//
// Directed and randomized bench for bamf_run_monitor. Each operand is paired
// with a planned datapath latency and outport value. A datapath model writes
// the outport in that RUN cycle. From the plan the bench predicts the exact
// cycle-by-cycle control outputs and the result returned for every run.
// ---------------------------------------------------------------------------
module tb_bamf_run_monitor;

    localparam int DATA_W     = 16;
    localparam int CNT_W      = 32;
    localparam int DEPTH      = 4;
    localparam int MAX_CYCLES = 50;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_data;
    logic [DATA_W-1:0] cpu_inport;
    logic              cpu_restart;
    logic              cpu_run;
    logic              cpu_out_valid;
    logic [DATA_W-1:0] cpu_outport;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [CNT_W-1:0]  res_cycles;
    logic              res_timeout;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Operands not yet offered, with their planned latency and outport value
    logic [DATA_W-1:0] pend_op [$];
    int                pend_lat [$];
    logic [DATA_W-1:0] pend_val [$];
    // Operands accepted by the block but not yet popped
    logic [DATA_W-1:0] fifo_op [$];
    int                fifo_lat [$];
    logic [DATA_W-1:0] fifo_val [$];

    int                cyc = 0;
    bit                pushed_last = 0;
    logic [DATA_W-1:0] push_op;
    int                push_lat;
    logic [DATA_W-1:0] push_val;
    int                push_cyc = 0;
    bit                hs_last = 0;
    int                hs_cyc = 0;
    bit                active = 0;
    bit                done = 0;
    bit                start_pending = 0;
    bit                end_pending = 0;
    bit                restart_now = 0;
    bit                run_now = 0;
    int                run_left = 0;
    int                run_k = 0;
    logic [DATA_W-1:0] cur_op;
    int                cur_lat = 0;
    logic [DATA_W-1:0] cur_val;
    logic [DATA_W-1:0] model_inport = '0;
    logic [DATA_W-1:0] exp_data;
    int                exp_cycles;
    bit                exp_to;
    int                rr_mode = 0;
    bit                gappy = 0;
    int                obs_restart_cyc = 0;
    bit                obs_restart = 0;
    int                obs_results = 0;

    bamf_run_monitor #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .DEPTH     (DEPTH),
        .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_data      (op_data),
        .cpu_inport   (cpu_inport),
        .cpu_restart  (cpu_restart),
        .cpu_run      (cpu_run),
        .cpu_out_valid(cpu_out_valid),
        .cpu_outport  (cpu_outport),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_cycles   (res_cycles),
        .res_timeout  (res_timeout),
        .busy         (busy)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBound(input string tag, input int used, input int budget);
        n_checks++;
        assert (used < budget) else begin
            n_fail++;
            $error("[TB] FAIL %s: waited %0d cycles, limit %0d", tag, used, budget);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_op_ready"},    64'(op_ready),    64'(1));
        checkOutput({tag, "_cpu_inport"},  64'(cpu_inport),  64'(0));
        checkOutput({tag, "_cpu_restart"}, 64'(cpu_restart), 64'(0));
        checkOutput({tag, "_cpu_run"},     64'(cpu_run),     64'(0));
        checkOutput({tag, "_res_valid"},   64'(res_valid),   64'(0));
        checkOutput({tag, "_res_data"},    64'(res_data),    64'(0));
        checkOutput({tag, "_res_cycles"},  64'(res_cycles),  64'(0));
        checkOutput({tag, "_res_timeout"}, 64'(res_timeout), 64'(0));
        checkOutput({tag, "_busy"},        64'(busy),        64'(0));
    endtask

    task automatic clearModel();
        pend_op.delete();  pend_lat.delete();  pend_val.delete();
        fifo_op.delete();  fifo_lat.delete();  fifo_val.delete();
        pushed_last = 0; hs_last = 0; active = 0; done = 0;
        start_pending = 0; end_pending = 0; restart_now = 0; run_now = 0;
        run_left = 0; run_k = 0; model_inport = '0;
        op_valid = 1'b0; cpu_out_valid = 1'b0; res_ready = 1'b0;
    endtask

    task automatic queueOp(input logic [DATA_W-1:0] op, input int lat,
                           input logic [DATA_W-1:0] val);
        pend_op.push_back(op);
        pend_lat.push_back(lat);
        pend_val.push_back(val);
    endtask

    // One clock cycle: update the model for the previous edge, check every
    // output against it, then drive the inputs for the next edge.
    task automatic stepCycle();
        int occ;
        @(negedge clk);
        cyc++;
        obs_restart = (cpu_restart === 1'b1);
        if (obs_restart) obs_restart_cyc = cyc;
        if (pushed_last) begin
            fifo_op.push_back(push_op);
            fifo_lat.push_back(push_lat);
            fifo_val.push_back(push_val);
            pushed_last = 0;
        end
        if (hs_last) begin
            active = 0;
            done = 0;
            hs_last = 0;
        end
        if (end_pending) begin
            done = 1;
            end_pending = 0;
        end
        restart_now = start_pending;
        start_pending = 0;
        run_now = 0;
        if (restart_now) begin
            run_left = (cur_lat <= MAX_CYCLES) ? cur_lat : MAX_CYCLES;
            run_k = 0;
            model_inport = cur_op;
            if (cur_lat <= MAX_CYCLES) begin
                exp_data = cur_val; exp_cycles = cur_lat; exp_to = 0;
            end else begin
                exp_data = '0; exp_cycles = MAX_CYCLES; exp_to = 1;
            end
        end else if (run_left > 0) begin
            run_now = 1;
            run_k++;
            run_left--;
            if (run_left == 0) end_pending = 1;
        end
        occ = fifo_op.size();

        checkOutput("cpu_restart", 64'(cpu_restart), 64'(restart_now));
        checkOutput("cpu_run",     64'(cpu_run),     64'(run_now));
        checkOutput("res_valid",   64'(res_valid),   64'(done));
        checkOutput("op_ready",    64'(op_ready),    64'(occ < DEPTH));
        checkOutput("busy",        64'(busy),        64'(active || occ > 0));
        checkOutput("cpu_inport",  64'(cpu_inport),  64'(model_inport));
        if (done) begin
            checkOutput("res_data",    64'(res_data),    64'(exp_data));
            checkOutput("res_cycles",  64'(res_cycles),  64'(exp_cycles));
            checkOutput("res_timeout", 64'(res_timeout), 64'(exp_to));
        end

        if (!active && occ > 0) begin
            active = 1;
            start_pending = 1;
            cur_op  = fifo_op.pop_front();
            cur_lat = fifo_lat.pop_front();
            cur_val = fifo_val.pop_front();
        end

        if (run_now && run_k == cur_lat) begin
            cpu_out_valid = 1'b1;
            cpu_outport   = cur_val;
        end else begin
            cpu_out_valid = run_now ? 1'b0 : 1'($urandom_range(0, 1));
            cpu_outport   = 16'($urandom);
        end

        case (rr_mode)
            0:       res_ready = 1'b1;
            1:       res_ready = 1'($urandom_range(0, 1));
            default: res_ready = 1'b0;
        endcase
        if (res_valid === 1'b1 && res_ready) obs_results++;
        if (done && res_ready) begin
            hs_last = 1;
            hs_cyc = cyc;
        end

        if (pend_op.size() > 0 && (!gappy || $urandom_range(0, 1) == 1)) begin
            op_valid = 1'b1;
            op_data  = pend_op[0];
            if (occ < DEPTH) begin
                pushed_last = 1;
                push_op  = pend_op.pop_front();
                push_lat = pend_lat.pop_front();
                push_val = pend_val.pop_front();
                push_cyc = cyc;
            end
        end else begin
            op_valid = 1'b0;
            op_data  = 16'($urandom);
        end
    endtask

    task automatic applyStimulus(input int ncycles);
        repeat (ncycles) stepCycle();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pend_op.size() > 0 || fifo_op.size() > 0 || pushed_last || active)
               && n < budget) begin
            stepCycle();
            n++;
        end
        checkBound({tag, "_drain"}, n, budget);
        stepCycle();
        checkOutput({tag, "_idle_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int n;
        int base;
        reset_n = 1'b1;
        op_valid = 1'b0; op_data = '0;
        cpu_out_valid = 1'b0; cpu_outport = '0;
        res_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        reset_n = 1'b1;

        // Single run: outport written in RUN cycle 37, restart two cycles after push
        $display("[TB] single run");
        rr_mode = 0; gappy = 0;
        queueOp(16'h13B0, 37, 16'h000B);
        base = obs_results;
        n = 0;
        while (!obs_restart && n < 20) begin stepCycle(); n++; end
        checkBound("single_wait_restart", n, 20);
        checkOutput("single_restart_latency", 64'(obs_restart_cyc - push_cyc), 64'(2));
        drain("single", 200);
        checkOutput("single_results", 64'(obs_results - base), 64'(1));

        // Timeout: the datapath never answers
        $display("[TB] timeout");
        queueOp(16'h0010, 100000, 16'hFFFF);
        drain("timeout", 200);

        // Outport write in the same cycle as the bound
        $display("[TB] simultaneous");
        queueOp(16'h0020, MAX_CYCLES, 16'h0003);
        drain("simul", 200);

        // Five operands against a four-entry FIFO
        $display("[TB] fifo full and batch");
        base = obs_results;
        queueOp(16'h0101, 20, 16'h1111);
        queueOp(16'h0202, 25, 16'h2222);
        queueOp(16'h0303, 30, 16'h3333);
        queueOp(16'h0404, 12, 16'h4444);
        queueOp(16'h0505, 7,  16'h5555);
        n = 0;
        while (fifo_op.size() < DEPTH && n < 40) begin stepCycle(); n++; end
        checkBound("batch_wait_full", n, 40);
        checkOutput("batch_full_op_ready", 64'(op_ready), 64'(0));
        drain("batch", 800);
        checkOutput("batch_results", 64'(obs_results - base), 64'(5));

        // Backpressure: hold the result for 20 cycles with a second operand queued
        $display("[TB] backpressure");
        rr_mode = 2;
        queueOp(16'h0A0A, 5, 16'hABCD);
        queueOp(16'h0B0B, 8, 16'hBCDE);
        n = 0;
        while (!done && n < 100) begin stepCycle(); n++; end
        checkBound("bp_wait_done", n, 100);
        applyStimulus(20);
        checkOutput("bp_held_valid", 64'(res_valid), 64'(1));
        rr_mode = 0;
        n = 0;
        obs_restart = 0;
        while (!obs_restart && n < 10) begin stepCycle(); n++; end
        checkBound("bp_wait_restart", n, 10);
        checkOutput("bp_restart_latency", 64'(obs_restart_cyc - hs_cyc), 64'(2));
        drain("bp", 200);

        // Randomized batch with random gaps and consumer stalls
        $display("[TB] random");
        rr_mode = 1; gappy = 1;
        base = obs_results;
        for (int i = 0; i < 16; i++) begin
            int r;
            int lat;
            r = $urandom_range(0, 9);
            if (r == 0)      lat = MAX_CYCLES;
            else if (r == 1) lat = MAX_CYCLES - 1;
            else if (r == 2) lat = MAX_CYCLES + 1 + $urandom_range(0, 20);
            else             lat = $urandom_range(1, 45);
            queueOp(16'($urandom), lat, 16'($urandom));
        end
        drain("random", 5000);
        checkOutput("random_results", 64'(obs_results - base), 64'(16));

        // Reset in RUN cycle 10 with two operands still queued
        $display("[TB] reset mid-run");
        rr_mode = 0; gappy = 0;
        queueOp(16'h0C0C, 40, 16'h0C0C);
        queueOp(16'h0D0D, 40, 16'h0D0D);
        queueOp(16'h0E0E, 40, 16'h0E0E);
        n = 0;
        while (!(run_now && run_k == 10) && n < 50) begin stepCycle(); n++; end
        checkBound("rst_wait_run10", n, 50);
        checkOutput("rst_queued_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        #1;
        checkReset("midrun_reset");
        clearModel();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        base = obs_results;
        applyStimulus(80);
        checkOutput("rst_no_results", 64'(obs_results - base), 64'(0));
        checkReset("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
